// File: rtl/rotfpga_cfg_pkg.sv
// Shared types and CRC-8 helper for the rotatable-tile FPGA scan-chain loader.
package rotfpga_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } cfg_state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  // One bit-serial CRC-8 step, message bit entering at the top.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic bit_in);
    logic fb;
    fb = crc_in[7] ^ bit_in;
    return {crc_in[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/rotfpga_crc8.sv
// Bit-serial CRC-8 accumulator with synchronous clear and per-bit enable.
module rotfpga_crc8
  import rotfpga_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= 8'h00;
    end else if (clr) begin
      crc <= 8'h00;
    end else if (en) begin
      crc <= crc8_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/rotfpga_cfg_loader.sv
// Scan-chain configuration initiator: byte stream in, MSB-first two-phase scan
// shifting, optional recirculating CRC readback, then fabric release / free-run.
module rotfpga_cfg_loader
  import rotfpga_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 256,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       verify,
  input  logic       run_en,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       sc_clk,
  output logic       sc_se,
  output logic       sc_in,
  input  logic       sc_out,
  output logic       fab_rst_n,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] crc
);

  localparam logic [CNT_W-1:0] CHAIN_CNT = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  cfg_state_t       state_q;
  cfg_state_t       state_d;
  logic [7:0]       sr;
  logic [3:0]       sr_cnt;
  logic [CNT_W-1:0] bit_cnt;
  logic             verify_q;
  logic [7:0]       crc_rb;

  logic             start_ok;
  logic             accept;
  logic             end_l;
  logic             end_h;
  logic             last_bit;

  // bit_cnt counts bits not yet shifted out; bits still to be accepted are
  // bit_cnt - sr_cnt, which stops byte acceptance after CHAIN_LEN/8 bytes.
  always_comb begin
    state_d  = state_q;
    s_ready  = 1'b0;
    start_ok = 1'b0;
    accept   = 1'b0;
    end_l    = 1'b0;
    end_h    = 1'b0;
    last_bit = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        start_ok = start;
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        s_ready  = ((sr_cnt == 4'd0) || ((sr_cnt == 4'd1) && sc_clk)) &&
                   (bit_cnt > {{(CNT_W-4){1'b0}}, sr_cnt});
        accept   = s_valid && s_ready;
        end_l    = (sr_cnt != 4'd0) && !sc_clk;
        end_h    = sc_clk;
        last_bit = sc_clk && (bit_cnt == CNT_ONE);
        if (last_bit) state_d = verify_q ? ST_VERIFY : ST_DONE;
      end
      ST_VERIFY: begin
        end_l    = !sc_clk;
        end_h    = sc_clk;
        last_bit = sc_clk && (bit_cnt == CNT_ONE);
        if (last_bit) state_d = ST_DONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr        <= 8'h00;
      sr_cnt    <= 4'd0;
      bit_cnt   <= '0;
      verify_q  <= 1'b0;
      sc_clk    <= 1'b0;
      sc_se     <= 1'b0;
      fab_rst_n <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            busy      <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            sc_se     <= 1'b1;
            fab_rst_n <= 1'b0;
            sc_clk    <= 1'b0;
            bit_cnt   <= CHAIN_CNT;
            sr_cnt    <= 4'd0;
            verify_q  <= verify;
          end else begin
            sc_clk <= run_en ? ~sc_clk : 1'b0;
          end
        end
        ST_LOAD: begin
          if (end_l) sc_clk <= 1'b1;
          if (end_h) begin
            sc_clk  <= 1'b0;
            sr      <= {sr[6:0], 1'b0};
            sr_cnt  <= sr_cnt - 4'd1;
            bit_cnt <= bit_cnt - CNT_ONE;
          end
          // A byte taken during the last H replaces the drained register.
          if (accept) begin
            sr     <= s_data;
            sr_cnt <= 4'd8;
          end
          if (last_bit) begin
            if (verify_q) begin
              bit_cnt <= CHAIN_CNT;
            end else begin
              busy      <= 1'b0;
              done      <= 1'b1;
              sc_se     <= 1'b0;
              fab_rst_n <= 1'b1;
            end
          end
        end
        ST_VERIFY: begin
          if (end_l) sc_clk <= 1'b1;
          if (end_h) begin
            sc_clk  <= 1'b0;
            bit_cnt <= bit_cnt - CNT_ONE;
          end
          if (last_bit) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            err       <= (crc_rb != crc);
            sc_se     <= 1'b0;
            fab_rst_n <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Readback recirculates scan-out straight back into scan-in.
  assign sc_in = (state_q == ST_VERIFY) ? sc_out : sr[7];

  rotfpga_crc8 u_crc_load (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (start_ok),
    .en     ((state_q == ST_LOAD) && end_l),
    .bit_in (sr[7]),
    .crc    (crc)
  );

  rotfpga_crc8 u_crc_readback (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (start_ok),
    .en     ((state_q == ST_VERIFY) && end_l),
    .bit_in (sc_out),
    .crc    (crc_rb)
  );

endmodule

// File: tb/tb_rotfpga_cfg_loader.sv
// Self-checking bench for rotfpga_cfg_loader with a 16-bit shift-register grid model.
module tb_rotfpga_cfg_loader;

  localparam int N = 16;
  localparam logic [N-1:0] FLIP_MASK = 16'h0100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       verify = 1'b0;
  logic       run_en = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic       sc_clk;
  logic       sc_se;
  logic       sc_in;
  logic       sc_out;
  logic       fab_rst_n;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] crc;

  typedef struct {
    logic [7:0]   b0;
    logic [7:0]   b1;
    bit           verify;
    bit           flip;
    bit           gap;
    bit           restart;
    logic [N-1:0] exp_chain;
    bit           exp_err;
    logic [7:0]   exp_crc;
    int           exp_cycles;
    int           exp_shifts;
  } vec_t;

  typedef struct {
    logic [N-1:0] chain;
    bit           err;
    logic [7:0]   crc;
    int           cycles;
    int           shifts;
  } exp_t;

  vec_t vecs [7];
  exp_t sb [$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t_first = 0;
  int base_shifts = 0;
  int flip_req = 0;
  int flip_ack = 0;
  bit flip_armed = 1'b0;

  logic [N-1:0] chain = '0;
  int           shifts = 0;

  rotfpga_cfg_loader #(.CHAIN_LEN(N), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .verify    (verify),
    .run_en    (run_en),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .sc_clk    (sc_clk),
    .sc_se     (sc_se),
    .sc_in     (sc_in),
    .sc_out    (sc_out),
    .fab_rst_n (fab_rst_n),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .crc       (crc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Grid model: scan chain shifting toward the MSB on rising sc_clk while enabled;
  // a pending corruption request is applied just before the next shift.
  assign sc_out = chain[N-1];
  always @(posedge sc_clk) begin : grid_model
    logic [N-1:0] m;
    m = (flip_req != flip_ack) ? FLIP_MASK : '0;
    if (sc_se) begin
      chain  <= {chain[N-2:0] ^ m[N-2:0], sc_in};
      shifts <= shifts + 1;
    end
    flip_ack <= flip_req;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] crc_ref(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] c;
    logic [7:0] msg [2];
    c = 8'h00;
    msg[0] = a;
    msg[1] = b;
    for (int i = 0; i < 2; i++) begin
      c = c ^ msg[i];
      for (int j = 0; j < 8; j++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  task automatic compareValue(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic checkResetValues(input string tag);
    compareValue({tag, "_sc_clk"}, 32'(sc_clk), 0);
    compareValue({tag, "_sc_se"}, 32'(sc_se), 0);
    compareValue({tag, "_sc_in"}, 32'(sc_in), 0);
    compareValue({tag, "_fab_rst_n"}, 32'(fab_rst_n), 0);
    compareValue({tag, "_s_ready"}, 32'(s_ready), 0);
    compareValue({tag, "_busy"}, 32'(busy), 0);
    compareValue({tag, "_done"}, 32'(done), 0);
    compareValue({tag, "_err"}, 32'(err), 0);
    compareValue({tag, "_crc"}, 32'(crc), 0);
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    int   t0;
    int   guard;
    t0 = 0;
    @(negedge clk);
    start  = 1'b1;
    verify = v.verify;
    @(negedge clk);
    start  = 1'b0;
    verify = 1'b0;
    base_shifts = shifts;
    e.chain  = v.exp_chain;
    e.err    = v.exp_err;
    e.crc    = v.exp_crc;
    e.cycles = v.exp_cycles;
    e.shifts = v.exp_shifts;
    sb.push_back(e);
    flip_armed = v.flip;
    for (int k = 0; k < 2; k++) begin
      s_data  = (k == 0) ? v.b0 : v.b1;
      s_valid = 1'b1;
      guard = 0;
      while (!s_ready && guard < 64) begin
        @(negedge clk);
        guard++;
      end
      compareValue("accept_wait", 32'(s_ready), 1);
      if (k == 0) t0 = cyc;
      @(negedge clk);
      s_valid = 1'b0;
      if (k == 0 && v.restart) begin
        start  = 1'b1;
        verify = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        verify = 1'b0;
      end
      if (k == 0 && v.gap) begin
        while (cyc < t0 + 21) begin
          if (cyc >= t0 + 17) compareValue("gap_sc_clk_low", 32'(sc_clk), 0);
          @(negedge clk);
        end
      end
    end
    t_first = t0;
  endtask

  task automatic checkOutput();
    exp_t e;
    int   guard;
    guard = 0;
    while (!done && guard < 400) begin
      if (flip_armed && (shifts - base_shifts) == N) begin
        flip_req++;
        flip_armed = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    compareValue("sb_nonempty", 32'(sb.size() > 0), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    compareValue("done", 32'(done), 1);
    compareValue("latency", 32'(cyc - t_first), 32'(e.cycles));
    compareValue("busy_low", 32'(busy), 0);
    compareValue("err", 32'(err), 32'(e.err));
    compareValue("fab_rst_n", 32'(fab_rst_n), 1);
    compareValue("sc_se_low", 32'(sc_se), 0);
    compareValue("crc", 32'(crc), 32'(e.crc));
    compareValue("chain", 32'(chain), 32'(e.chain));
    compareValue("shift_count", 32'(shifts - base_shifts), 32'(e.shifts));
  endtask

  initial begin
    logic [N-1:0] snap;

    vecs[0] = '{8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 16'hA53C, 1'b0, 8'hED, 33, 16};
    vecs[1] = '{8'hA5, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 16'hA53C, 1'b0, 8'hED, 65, 32};
    vecs[2] = '{8'hA5, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 16'hA43C, 1'b1, 8'hED, 65, 32};
    vecs[3] = '{8'hA5, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 16'hA53C, 1'b0, 8'hED, 38, 16};
    vecs[4] = '{8'h5A, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5AC3, 1'b0, crc_ref(8'h5A, 8'hC3), 33, 16};
    vecs[5] = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 16'h00FF, 1'b0, crc_ref(8'h00, 8'hFF), 65, 32};
    vecs[6] = '{8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 16'hFF00, 1'b0, crc_ref(8'hFF, 8'h00), 70, 32};

    repeat (3) @(negedge clk);
    checkResetValues("por");
    rst_n = 1'b1;
    @(negedge clk);
    compareValue("idle_busy", 32'(busy), 0);

    for (int i = 0; i < 7; i++) begin
      $display("[TB] vector %0d bytes %02h %02h verify=%0d", i, vecs[i].b0, vecs[i].b1, vecs[i].verify);
      applyStimulus(vecs[i]);
      checkOutput();
    end

    $display("[TB] free-run clock in DONE");
    snap = chain;
    compareValue("run_pre_sc_clk", 32'(sc_clk), 0);
    run_en = 1'b1;
    @(negedge clk);
    compareValue("run_sc_clk_1", 32'(sc_clk), 1);
    compareValue("run_sc_se_1", 32'(sc_se), 0);
    @(negedge clk);
    compareValue("run_sc_clk_2", 32'(sc_clk), 0);
    @(negedge clk);
    compareValue("run_sc_clk_3", 32'(sc_clk), 1);
    compareValue("run_sc_se_3", 32'(sc_se), 0);
    run_en = 1'b0;
    @(negedge clk);
    compareValue("run_stop_sc_clk_a", 32'(sc_clk), 0);
    @(negedge clk);
    compareValue("run_stop_sc_clk_b", 32'(sc_clk), 0);
    compareValue("run_chain_kept", 32'(chain), 32'(snap));
    compareValue("run_done_held", 32'(done), 1);

    $display("[TB] reset during load");
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    s_data  = 8'hC3;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (4) @(negedge clk);
    compareValue("mid_load_busy", 32'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    checkResetValues("midrst");
    rst_n = 1'b1;
    @(negedge clk);
    compareValue("post_rst_busy", 32'(busy), 0);
    compareValue("post_rst_s_ready", 32'(s_ready), 0);
    applyStimulus(vecs[0]);
    checkOutput();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rotfpga_cfg_loader.md
# rotfpga_cfg_loader

Scan-chain configuration initiator for the rotatable-tile FPGA grid. Accepts a configuration bitstream as a byte stream, serialises it MSB-first into the grid's scan chain (drives the grid's clock, scan-enable and scan-in, reads its scan-out), optionally performs a non-destructive recirculating readback with CRC-8 compare, then releases the fabric from reset and can free-run its clock. It sits between a host byte source and the grid's `clk`, `rst_n`, `in_se`, `in_sc`, `out_sc` pins.

## Interface
- `CHAIN_LEN`, 256: scan-chain length in bits; multiple of 8, ≥ 8.
- `CNT_W`, 16: bit-counter width; 2^CNT_W > CHAIN_LEN.

- `clk` in 1: system clock. One clock; reset is asynchronous and active-low (`rst_n`).
- `rst_n` in 1: async active-low reset.
- `start` in 1: one-cycle pulse; begins a load. Ignored unless `busy`=0.
- `verify` in 1: sampled with `start`; 1 = readback pass after load.
- `run_en` in 1: free-run fabric clock when not busy.
- `s_data` in 8: bitstream byte, MSB shifted first.
- `s_valid` in 1: `s_data` valid.
- `s_ready` out 1: byte accepted when `s_valid & s_ready`.
- `sc_clk` out 1: drives grid `clk`.
- `sc_se` out 1: drives grid `in_se`.
- `sc_in` out 1: drives grid `in_sc`.
- `sc_out` in 1: from grid `out_sc`.
- `fab_rst_n` out 1: drives grid `rst_n`.
- `busy`, `done`, `err` out 1 each: status.
- `crc` out 8: CRC-8 of bits loaded.

## Operation
- States: IDLE, LOAD, VERIFY, DONE.
- Bit slot = two cycles: L (`sc_clk`=0, `sc_in` stable), H (`sc_clk`=1; grid samples on rising edge).
- IDLE/DONE + `start`: → LOAD; `busy`=1, `done`=0, `err`=0, `crc` cleared, `sc_se`=1, `fab_rst_n`=0, bit counter = CHAIN_LEN.
- LOAD: `s_ready`=1 when shift register empty, or during H of a byte's last bit (back-to-back, no gap). Empty register with no valid byte: stall with `sc_clk`=0. `sc_in`=shift-register MSB. CRC updated with each bit on the edge ending its L.
- After H of bit CHAIN_LEN: → VERIFY if `verify` latched, else DONE. Bytes beyond CHAIN_LEN/8 are not accepted (`s_ready`=0).
- VERIFY: CHAIN_LEN slots, no stalls; `sc_in` = `sc_out` combinationally (recirculate; chain restored after CHAIN_LEN shifts); readback CRC updated with `sc_out` on edge ending each L.
- DONE: `busy`=0, `done`=1 (held until next `start`), `err` = (readback CRC ≠ `crc`) if verify, else 0; `sc_se`=0, `fab_rst_n`=1.
- IDLE/DONE with `run_en`=1: `sc_clk` toggles every cycle (clk/2), `sc_se`=0; `run_en`=0: `sc_clk` returns to 0 after current high phase. `run_en` ignored in LOAD/VERIFY.
- CRC-8: poly 0x07, init 0x00, bit-serial: fb=crc[7]^b; crc={crc[6:0],0}^(fb?0x07:0).

## Timing
- All outputs registered except `sc_in` in VERIFY and `s_ready` (combinational from state/counters).
- Reset values: `sc_clk`=0, `sc_se`=0, `sc_in`=0, `fab_rst_n`=0, `s_ready`=0, `busy`=0, `done`=0, `err`=0, `crc`=0x00; state IDLE.
- Byte accepted at cycle t → its bit 7 on `sc_in` from t+1; 8 bits occupy t+1..t+16; continuous stream = 1 byte / 16 cycles.
- `start` to first L: 1 cycle plus byte acceptance.
- Load with no stalls: CHAIN_LEN·2 + 1 cycles from first acceptance to DONE; verify adds CHAIN_LEN·2.
- `start` while `busy`: ignored. `start` and `s_valid` same cycle in IDLE: byte not accepted that cycle.
- Reset mid-operation: immediate return to reset values; chain contents undefined; fabric held in reset.

## Structure
- Package `rotfpga_cfg_pkg`: state enum, `CRC8_POLY`=8'h07, `crc8_step` function.
- One sub-module `rotfpga_crc8` (bit-serial CRC with clear/enable), instantiated twice (load, readback).

## Test plan
- CHAIN_LEN=16, bytes 0xA5,0x3C, verify=0, grid model = shift register → model holds 0xA53C; `done`=1, `err`=0, `fab_rst_n`=1, `crc` = CRC-8(0xA53C)=expected reference value; total 33 cycles after first accept.
- Same with verify=1 → chain contents unchanged after VERIFY, `err`=0, 32 extra cycles.
- Verify=1 with one model bit flipped after load → `err`=1.
- `s_valid` deasserted 5 cycles mid-stream → `sc_clk` held 0 for the gap, final contents identical, no extra bits shifted.
- DONE with `run_en`=1 → `sc_clk` toggles 0,1,0,1 with `sc_se`=0; `start` while LOAD ignored.
- `rst_n` pulsed low mid-LOAD → all outputs at reset values next cycle, state IDLE, new `start` loads correctly.
